// File: rtl/ro_pkg.sv
// Shared types and constants for the ring-oscillator measurement sequencer.
package ro_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SETTLE,
    ST_GATE,
    ST_HOLD,
    ST_CAPTURE
  } ro_meas_state_t;

  localparam logic RO_ID_1 = 1'b0;
  localparam logic RO_ID_2 = 1'b1;

  localparam int DEF_CNT_W      = 16;
  localparam int DEF_WIN_W      = 16;
  localparam int DEF_SETTLE_CYC = 4;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic first_id(input logic [1:0] m);
    return m[0] ? RO_ID_1 : RO_ID_2;
  endfunction

  function automatic logic [1:0] id_onehot(input logic id);
    return (id == RO_ID_2) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ro_meas_timer.sv
// Loadable down-counter; o_tc flags a zero count.
// Holds at zero rather than wrapping.
module ro_meas_timer #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/ro_meas_ctrl.sv
// RO measurement sequencer: clear, settle, gate, hold, capture per RO.
// Define RO_MEAS_DIFF_EN to add the signed res_diff = res1 - res0 output.
module ro_meas_ctrl
  import ro_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int WIN_W      = DEF_WIN_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cont,
  input  logic [1:0]       ro_mask,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] ro_count,
  output logic [1:0]       ro_act,
  output logic             cnt_clr,
  output logic             cnt_gate,
  output logic             busy,
  output logic             res_valid,
  output logic             res_id,
  output logic [CNT_W-1:0] res0,
  output logic [CNT_W-1:0] res1,
  output logic             done
`ifdef RO_MEAS_DIFF_EN
  ,
  output logic signed [CNT_W:0] res_diff
`endif
);

  localparam int TW =
    max_i(WIN_W, $clog2(SETTLE_CYC + 1));

  ro_meas_state_t   r_state;
  logic [1:0]       r_mask;
  logic [WIN_W-1:0] r_win;
  logic             r_cont;

  logic          w_tc;
  logic          w_load;
  logic [TW-1:0] w_ld_val;
  logic          w_next_hi;

  // Timer reloads on every state change with the next state's length - 1.
  always_comb begin
    w_ld_val = '0;
    case (r_state)
      ST_CLEAR, ST_GATE:
        w_ld_val = TW'(SETTLE_CYC - 1);
      ST_SETTLE:
        w_ld_val = (r_win == '0) ? '0
                 : TW'(r_win) - TW'(1);
      default:
        w_ld_val = '0;
    endcase
  end

  assign w_load = (r_state == ST_IDLE) | w_tc;
  assign w_next_hi = (res_id == RO_ID_1) & r_mask[1];

  ro_meas_timer #(
    .W(TW)
  ) u_timer (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_load (w_load),
    .i_val  (w_ld_val),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_mask    <= '0;
      r_win     <= '0;
      r_cont    <= 1'b0;
      ro_act    <= '0;
      cnt_clr   <= 1'b0;
      cnt_gate  <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= RO_ID_1;
      res0      <= '0;
      res1      <= '0;
      done      <= 1'b0;
    end else if (abort) begin
      r_state   <= ST_IDLE;
      ro_act    <= '0;
      cnt_clr   <= 1'b0;
      cnt_gate  <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      cnt_clr   <= 1'b0;
      res_valid <= 1'b0;
      done      <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start && ro_mask != 2'b00) begin
            r_mask  <= ro_mask;
            r_win   <= win_len;
            r_cont  <= cont;
            res_id  <= first_id(ro_mask);
            ro_act  <= id_onehot(first_id(ro_mask));
            cnt_clr <= 1'b1;
            busy    <= 1'b1;
            r_state <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (w_tc) r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (w_tc) begin
            cnt_gate <= 1'b1;
            r_state  <= ST_GATE;
          end
        end
        ST_GATE: begin
          if (w_tc) begin
            cnt_gate <= 1'b0;
            r_state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_tc) begin
            ro_act    <= '0;
            res_valid <= 1'b1;
            if (res_id == RO_ID_2) res1 <= ro_count;
            else                   res0 <= ro_count;
            r_state   <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (w_next_hi) begin
            res_id  <= RO_ID_2;
            ro_act  <= id_onehot(RO_ID_2);
            cnt_clr <= 1'b1;
            r_state <= ST_CLEAR;
          end else if (r_cont) begin
            res_id  <= first_id(r_mask);
            ro_act  <= id_onehot(first_id(r_mask));
            cnt_clr <= 1'b1;
            r_state <= ST_CLEAR;
          end else begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef RO_MEAS_DIFF_EN
  // res1 already holds the new RO2 value while in CAPTURE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_diff <= '0;
    end else if (r_state == ST_CAPTURE &&
                 res_id == RO_ID_2 &&
                 r_mask == 2'b11) begin
      res_diff <= $signed({1'b0, res1})
                - $signed({1'b0, res0});
    end
  end
`endif

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Self-checking bench for ro_meas_ctrl: fixed vectors, hand sequences
// and random runs checked cycle by cycle against a timeline model.
module tb_ro_meas_ctrl;

  localparam int CNT_W = 16;
  localparam int WIN_W = 16;
  localparam int S     = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic             cont;
  logic [1:0]       ro_mask;
  logic [WIN_W-1:0] win_len;
  logic [CNT_W-1:0] ro_count;
  logic [1:0]       ro_act;
  logic             cnt_clr;
  logic             cnt_gate;
  logic             busy;
  logic             res_valid;
  logic             res_id;
  logic [CNT_W-1:0] res0;
  logic [CNT_W-1:0] res1;
  logic             done;
`ifdef RO_MEAS_DIFF_EN
  logic signed [CNT_W:0] res_diff;
`endif

  ro_meas_ctrl #(
    .CNT_W(CNT_W),
    .WIN_W(WIN_W),
    .SETTLE_CYC(S)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .cont(cont),
    .ro_mask(ro_mask),
    .win_len(win_len),
    .ro_count(ro_count),
    .ro_act(ro_act),
    .cnt_clr(cnt_clr),
    .cnt_gate(cnt_gate),
    .busy(busy),
    .res_valid(res_valid),
    .res_id(res_id),
    .res0(res0),
    .res1(res1),
    .done(done)
`ifdef RO_MEAS_DIFF_EN
    ,
    .res_diff(res_diff)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  logic [15:0] exp_res [2];
  logic [16:0] exp_diff;

  typedef struct {
    logic [1:0]  m;
    logic [15:0] w;
    logic [15:0] v0;
    logic [15:0] v1;
    int          cap;
    int          dn;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic logic [7:0] st();
    return {ro_act, cnt_clr, cnt_gate, busy,
            res_valid, res_id, done};
  endfunction

  function automatic logic [1:0] oh(input int id);
    return (id == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic chk_res(input string tag);
    chk({tag, " res0"}, 64'(res0), 64'(exp_res[0]));
    chk({tag, " res1"}, 64'(res1), 64'(exp_res[1]));
`ifdef RO_MEAS_DIFF_EN
    chk({tag, " diff"}, {47'b0, res_diff}, {47'b0, exp_diff});
`endif
  endtask

  // Expected outputs follow from the per-RO period P = 2+2S+W:
  // cycle k after the start edge sits at phase (k-1)%P of RO (k-1)/P.
  task automatic do_run(input logic [1:0] m, input logic [15:0] wl,
                        input logic c, input int ka, input logic fixed,
                        input logic [15:0] fv0, input logic [15:0] fv1,
                        output int first_cap, output int done_k);
    int idq[$];
    int wv, p, n, kmax, j, ph, id, last_id;
    logic [15:0] segval;
    logic [7:0] e;
    logic active, cap_prev1, dn;
    wv = (wl == 0) ? 1 : int'(wl);
    p = 2 + 2 * S + wv;
    if (m[0]) idq.push_back(0);
    if (m[1]) idq.push_back(1);
    n = idq.size();
    kmax = (ka > 0) ? ka + 3 : n * p + 3;
    first_cap = -1;
    done_k = -1;
    last_id = int'(res_id);
    cap_prev1 = 1'b0;
    segval = '0;
    @(negedge clk);
    start = 1'b1; ro_mask = m; win_len = wl;
    cont = c; abort = 1'b0;
    for (int k = 1; k <= kmax; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        ro_mask = 2'($urandom);
        win_len = 16'($urandom_range(0, 20));
        cont = 1'($urandom);
      end
      abort = (ka > 0 && k == ka);
      if (cap_prev1)
        exp_diff = 17'($signed({1'b0, exp_res[1]})
                     - $signed({1'b0, exp_res[0]}));
      cap_prev1 = 1'b0;
      active = !(ka > 0 && k > ka) && (c || k <= n * p);
      if (active) begin
        j = (k - 1) / p;
        ph = (k - 1) % p;
        id = idq[j % n];
        last_id = id;
        if (ph == 0) begin
          segval = fixed ? ((id == 1) ? fv1 : fv0)
                         : 16'($urandom);
          ro_count = segval;
        end
        if (ph == p - 1) begin
          exp_res[id] = segval;
          if (id == 1 && m == 2'b11) cap_prev1 = 1'b1;
        end
        e = {(ph < p - 1) ? oh(id) : 2'b00,
             ph == 0,
             ph >= S + 1 && ph <= S + wv,
             1'b1,
             ph == p - 1,
             id[0],
             1'b0};
      end else begin
        dn = (ka == 0) && !c && (k == n * p + 1);
        e = {6'b0, 1'(last_id), dn};
      end
      chk($sformatf("status k=%0d", k), 64'(st()), 64'(e));
      chk_res($sformatf("k=%0d", k));
      if (res_valid && first_cap < 0) first_cap = k;
      if (done && done_k < 0) done_k = k;
    end
    abort = 1'b0;
  endtask

  int fc, dk, p, n, ka;
  logic [1:0] m;
  logic [15:0] w;
  logic c;

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cont = 1'b0;
    ro_mask = 2'b00; win_len = '0; ro_count = '0;
    exp_res[0] = '0; exp_res[1] = '0; exp_diff = '0;

    tbl[0] = '{2'b01, 16'd10, 16'h1234, 16'h0000, 20, 21};
    tbl[1] = '{2'b11, 16'd10, 16'h0BEE, 16'hF00D, 20, 41};
    tbl[2] = '{2'b10, 16'd8,  16'h0000, 16'h5A5A, 18, 19};
    tbl[3] = '{2'b01, 16'd0,  16'h0042, 16'h0000, 11, 12};
    tbl[4] = '{2'b11, 16'd1,  16'h7FFF, 16'h8001, 11, 23};
    tbl[5] = '{2'b10, 16'd3,  16'h0000, 16'hFFFF, 13, 14};

    repeat (3) @(negedge clk);
    chk("reset status", 64'(st()), 64'd0);
    chk_res("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_run(tbl[i].m, tbl[i].w, 1'b0, 0, 1'b1,
             tbl[i].v0, tbl[i].v1, fc, dk);
      chk($sformatf("tbl%0d cap", i), 64'(fc), 64'(tbl[i].cap));
      chk($sformatf("tbl%0d done", i), 64'(dk), 64'(tbl[i].dn));
      if (tbl[i].m[0])
        chk($sformatf("tbl%0d r0", i), 64'(res0), 64'(tbl[i].v0));
      if (tbl[i].m[1])
        chk($sformatf("tbl%0d r1", i), 64'(res1), 64'(tbl[i].v1));
    end

    // start held through done re-arms immediately (P = 12).
    @(negedge clk);
    start = 1'b1; ro_mask = 2'b01; win_len = 16'd2;
    cont = 1'b0; ro_count = 16'h00A5;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      if (k == 14) start = 1'b0;
      if (k == 12 || k == 25)
        chk($sformatf("rearm valid k=%0d", k), 64'(res_valid), 64'd1);
      if (k == 13 || k == 26)
        chk($sformatf("rearm done k=%0d", k), 64'(done), 64'd1);
      if (k == 14) begin
        chk("rearm busy", 64'(busy), 64'd1);
        chk("rearm clr", 64'(cnt_clr), 64'd1);
      end
      if (k == 27) chk("rearm idle", 64'(busy), 64'd0);
    end
    exp_res[0] = 16'h00A5;
    chk_res("rearm");

    // Continuous RO2 only, abort in the fourth pass.
    do_run(2'b10, 16'd8, 1'b1, 59, 1'b0, '0, '0, fc, dk);
    chk("cont first cap", 64'(fc), 64'd18);
    chk("cont no done", 64'(dk), 64'hFFFF_FFFF_FFFF_FFFF);

    for (int i = 0; i < 12; i++) begin
      m = 2'($urandom_range(1, 3));
      w = 16'($urandom_range(0, 12));
      c = 1'($urandom_range(0, 1));
      n = (m == 2'b11) ? 2 : 1;
      p = 2 + 2 * S + ((w == 0) ? 1 : int'(w));
      if (c) ka = $urandom_range(p, 3 * p);
      else if ($urandom_range(0, 3) == 0)
        ka = $urandom_range(1, n * p);
      else ka = 0;
      do_run(m, w, c, ka, 1'b0, '0, '0, fc, dk);
    end

`ifdef RO_MEAS_DIFF_EN
    do_run(2'b11, 16'd5, 1'b0, 0, 1'b1, 16'd100, 16'd250, fc, dk);
    chk("diff pos", {47'b0, res_diff}, {47'b0, 17'd150});
    do_run(2'b11, 16'd5, 1'b0, 0, 1'b1, 16'd250, 16'd100, fc, dk);
    chk("diff neg", {47'b0, res_diff}, {47'b0, 17'h1FF6A});
`endif

    // Reset in the middle of GATE clears everything.
    @(negedge clk);
    start = 1'b1; ro_mask = 2'b11; win_len = 16'd10; cont = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    chk("mid gate", 64'(cnt_gate), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    exp_res[0] = '0; exp_res[1] = '0; exp_diff = '0;
    chk("rst gate status", 64'(st()), 64'd0);
    chk_res("rst gate");
    rst_n = 1'b1;

    // start with an empty mask is ignored.
    start = 1'b1; ro_mask = 2'b00;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("mask0 k=%0d", k), 64'(st()), 64'd0);
    end
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
